arm7tdmi_fetch: RTL

ARM7TDMI_FETCH -- requirements
Module: arm7tdmi_fetch

---
 rtl/arm7tdmi_fetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/arm7tdmi_fetch.sv
// ARM7TDMI instruction fetch unit: one outstanding word read feeding a 2-entry prefetch FIFO.
// Define ARM7TDMI_FETCH_THUMB_EN to enable the Thumb halfword stream; otherwise the stream is always ARM.
module arm7tdmi_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        thumb_mode,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;

  logic [31:0] word_mem  [2];
  logic [31:0] pc_mem    [2];
  logic        thumb_mem [2];

  logic        thumb_eff;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic [31:0] pc_inc;
  logic [31:0] flush_target;

`ifdef ARM7TDMI_FETCH_THUMB_EN
  assign thumb_eff    = thumb_mode;
  assign flush_target = thumb_mode ? {flush_pc[31:1], 1'b0} : {flush_pc[31:2], 2'b00};
`else
  logic unused_thumb_mode;
  assign unused_thumb_mode = thumb_mode;
  assign thumb_eff         = 1'b0;
  assign flush_target      = {flush_pc[31:2], 2'b00};
`endif

  assign pc_inc      = thumb_eff ? 32'd2 : 32'd4;
  assign mem_addr    = {fetch_pc_q[31:2], 2'b00};
  assign instr_valid = (count_q != 2'd0);
  // With two entries the free slot sits one past the head only when exactly one is occupied.
  assign wr_idx      = head_q ^ count_q[0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    mem_req    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   mem_req = 1'b1;
      HOLD:    mem_req = 1'b0;
      default: state_d = BOOT;
    endcase

    if (flush) begin
      // Redirect wins over everything, including a request still waiting on memory.
      mem_req    = 1'b0;
      count_d    = 2'd0;
      head_d     = 1'b0;
      fetch_pc_d = flush_target;
      state_d    = FETCH;
    end else begin
      push    = mem_req && mem_ready;
      pop     = instr_valid && !stall;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
      if (push) begin
        fetch_pc_d = fetch_pc_q + pc_inc;
      end
      if (state_q == FETCH && count_d == 2'd2) begin
        state_d = HOLD;
      end else if (state_q == HOLD && count_d != 2'd2) begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= 32'h0000_0000;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // NOTE: FIFO storage is not reset; outputs are masked by occupancy, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_idx]  <= mem_rdata;
      pc_mem[wr_idx]    <= fetch_pc_q;
      thumb_mem[wr_idx] <= thumb_eff;
    end
  end

  always_comb begin
    instruction = 32'h0000_0000;
    pc_out      = 32'h0000_0000;
    if (instr_valid) begin
      pc_out = pc_mem[head_q];
      if (!thumb_mem[head_q]) begin
        instruction = word_mem[head_q];
      end else if (pc_mem[head_q][1]) begin
        instruction = {16'h0000, word_mem[head_q][31:16]};
      end else begin
        instruction = {16'h0000, word_mem[head_q][15:0]};
      end
    end
  end

endmodule
